// File: rtl/seq_det_pkg.sv
// Shared types for the programmable serial sequence detector.
package seq_det_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HUNT = 2'd2
    } state_e;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module seq_det_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector: runtime pattern/mask, overlap control,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W    = 8,
    parameter int unsigned      CNT_W    = 8,
    parameter logic [PAT_W-1:0] DEF_PAT  = PAT_W'(8'b0111_0001),
    parameter logic [PAT_W-1:0] DEF_MASK = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_ovl,
    input  logic             din_vld,
    input  logic             din,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int unsigned        FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0]  FILL_HUNT = FILL_W'(PAT_W - 1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, mask_q;
    logic               ovl_q;
    logic               match_q, busy_q;
    logic               accept_c, hit_c;
    logic [PAT_W-1:0]   shift_c;

    // Configuration: clr outranks cfg_load, so a simultaneous load is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= DEF_PAT;
            mask_q <= DEF_MASK;
            ovl_q  <= 1'b1;
        end else if (!clr && cfg_load) begin
            pat_q  <= cfg_pat;
            mask_q <= cfg_mask;
            ovl_q  <= cfg_ovl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit_c;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Compare runs on the post-shift history so the pulse lands one cycle after the last bit
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        accept_c = en && din_vld && !clr && !cfg_load;
        shift_c  = {hist_q[PAT_W-2:0], din};
        hit_c    = accept_c
                   && (((shift_c ^ pat_q) & mask_q) == '0)
                   && (fill_q >= FILL_HUNT);

        if (clr || cfg_load) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = en ? ST_FILL : ST_IDLE;
        end else if (!en) begin
            fill_d  = '0;
            state_d = ST_IDLE;
        end else begin
            if (accept_c) begin
                hist_d = shift_c;
                if (hit_c && !ovl_q) begin
                    fill_d = '0;
                end else if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end

            case (state_q)
                ST_IDLE, ST_FILL: state_d = (fill_d >= FILL_HUNT) ? ST_HUNT : ST_FILL;
                ST_HUNT:          state_d = (hit_c && !ovl_q) ? ST_FILL : ST_HUNT;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (hit_c),
        .cnt   (match_cnt)
    );

    assign match = match_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them.
module tb_seq_detect_prog;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             en       = 1'b0;
    logic             clr      = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat  = '0;
    logic [PAT_W-1:0] cfg_mask = '0;
    logic             cfg_ovl  = 1'b0;
    logic             din_vld  = 1'b0;
    logic             din      = 1'b0;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             busy;

    typedef struct packed {
        logic             m;
        logic [CNT_W-1:0] c;
        logic             b;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_mask  (cfg_mask),
        .cfg_ovl   (cfg_ovl),
        .din_vld   (din_vld),
        .din       (din),
        .match     (match),
        .match_cnt (match_cnt),
        .busy      (busy)
    );

    // Monitor: one expected entry per clock edge issued by the stimulus
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_chk++;
            if ({match, match_cnt, busy} !== mon_e) begin
                n_fail++;
                $display("FAIL out[%0d]: got match=%0b cnt=%0d busy=%0b, want match=%0b cnt=%0d busy=%0b",
                         n_out, match, match_cnt, busy, mon_e.m, mon_e.c, mon_e.b);
            end
            n_out++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step(input logic s_en, input logic s_clr, input logic s_load,
                        input logic s_vld, input logic s_din, input logic em, input int ec);
        exp_t x;
        en       = s_en;
        clr      = s_clr;
        cfg_load = s_load;
        din_vld  = s_vld;
        din      = s_din;
        @(posedge clk);
        #1;
        x.m = em;
        x.c = CNT_W'(ec);
        x.b = s_en;
        exp_q.push_back(x);
    endtask

    task automatic bit_in(input logic d, input logic em, input int ec);
        step(1'b1, 1'b0, 1'b0, 1'b1, d, em, ec);
    endtask

    task automatic do_clr();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                        input logic o, input int ec);
        cfg_pat  = p;
        cfg_mask = m;
        cfg_ovl  = o;
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ec);
    endtask

    // Eight bits MSB first; only the last may match
    task automatic send8(input logic [7:0] v, input logic last_m, input int c0, input int c1);
        for (int i = 7; i >= 1; i--) bit_in(v[i], 1'b0, c0);
        bit_in(v[0], last_m, c1);
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        logic [7:0] blk;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_match", int'(match), 0);
        check("reset_cnt", int'(match_cnt), 0);
        check("reset_busy", int'(busy), 0);

        // Default pattern 0111_0001
        send8(8'h71, 1'b1, 0, 1);
        do_clr();

        // Alternating pattern, overlap on then off
        load(8'hAA, 8'hFF, 1'b1, 0);
        send8(8'hAA, 1'b1, 0, 1);
        bit_in(1'b1, 1'b0, 1);
        bit_in(1'b0, 1'b1, 2);
        load(8'hAA, 8'hFF, 1'b0, 2);
        send8(8'hAA, 1'b1, 2, 3);
        bit_in(1'b1, 1'b0, 3);
        bit_in(1'b0, 1'b0, 3);
        do_clr();

        // Gaps in din_vld do not break the sequence
        load(8'h71, 8'hFF, 1'b1, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b1, 1);

        // Dropping en restarts the fill; held history alone must not match
        bit_in(1'b0, 1'b0, 1);
        bit_in(1'b1, 1'b0, 1);
        bit_in(1'b1, 1'b0, 1);
        bit_in(1'b1, 1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        bit_in(1'b0, 1'b0, 1);
        bit_in(1'b0, 1'b0, 1);
        bit_in(1'b0, 1'b0, 1);
        bit_in(1'b1, 1'b0, 1);
        send8(8'h71, 1'b1, 1, 2);
        do_clr();

        // Upper nibble compared, lower nibble don't-care, every combination
        load(8'hF0, 8'hF0, 1'b0, 0);
        for (int k = 0; k < 16; k++) begin
            blk = {4'hF, 4'(k)};
            send8(blk, 1'b1, sat3(k), sat3(k + 1));
        end
        do_clr();

        // Counter saturation, then clr on the completing bit
        load(8'h71, 8'hFF, 1'b1, 0);
        for (int k = 0; k < 5; k++) send8(8'h71, 1'b1, sat3(k), sat3(k + 1));
        do_clr();
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        bit_in(1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);

        // Async reset while match is high restores the default pattern
        load(8'hAA, 8'hFF, 1'b1, 0);
        send8(8'hAA, 1'b1, 0, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_match", int'(match), 0);
        check("arst_cnt", int'(match_cnt), 0);
        check("arst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send8(8'hAA, 1'b0, 0, 0);
        send8(8'h71, 1'b1, 0, 1);

        repeat (2) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
